// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter with run/pause/done control, optional
// wrap-around at zero and a registered one-cycle expiry pulse.
module bcd_down_timer #(
  parameter int DIGITS    = 3,
  parameter int MAX_DIGIT = 9,
  parameter bit WRAP      = 1'b0
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                loadN,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                expired,
  output logic                running
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DIGIT);

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] dec_value;
  logic [4*DIGITS-1:0] load_value;
  logic                expired_q, expired_d;
  logic                running_q;
  logic                dec_zero;
  logic                borrow;

  // Borrow chain: digit i steps only while every lower digit is zero; a zero
  // digit that must borrow reloads to MAXD, so all-zero becomes all-MAXD.
  always_comb begin
    dec_value = '0;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow) begin
        dec_value[4*i +: 4] = count_q[4*i +: 4];
      end else if (count_q[4*i +: 4] == 4'd0) begin
        dec_value[4*i +: 4] = MAXD;
      end else begin
        dec_value[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
        borrow              = 1'b0;
      end
    end
    dec_zero = (dec_value == '0);
  end

  // Clamp each preset digit so the counter never holds a digit above MAXD.
  always_comb begin
    load_value = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > MAXD) begin
        load_value[4*i +: 4] = MAXD;
      end else begin
        load_value[4*i +: 4] = preset[4*i +: 4];
      end
    end
  end

  // Next-state, next-count and expiry decision with load > pause > start > tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (!loadN) begin
      count_d = load_value;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!pause && start) begin
            if (tc && !WRAP) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            count_d = dec_value;
            if (!tc && dec_zero) begin
              expired_d = 1'b1;
              if (!WRAP) begin
                state_d = DONE;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause && start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, count and output registers; reset restores the all-MAXD count in IDLE.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      count_q   <= {DIGITS{MAXD}};
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      running_q <= (state_d == RUN);
    end
  end

  assign count   = count_q;
  assign tc      = (count_q == '0);
  assign expired = expired_q;
  assign running = running_q;

endmodule
